store_write_buffer: RTL and testbench
=====================================

# store_write_buffer

Write-side companion to the pipeline's data memory. Accepts store requests from the MEM stage over a valid/ready handshake and queues them in a small in-order FIFO. Drains them one per cycle onto the memory's registered write port. Forwards the youngest pending store data to same-address loads so reads never see stale memory.

## Interface
- mem_size, 256, number of memory words
- log_mem_size, 8, address and data width in bits
- depth, 4, buffer entries; power of two, at least 2

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- st_valid  in  1  store request present
- st_ready  out  1  buffer can accept; equals count < depth
- st_addr  in  log_mem_size  store address
- st_data  in  log_mem_size  store data
- mem_stall  in  1  memory write port busy; blocks drain
- mem_we  out  1  registered write strobe, one cycle per store
- mem_waddr  out  log_mem_size  registered write address
- mem_wdata  out  log_mem_size  registered write data
- fwd_addr  in  log_mem_size  load address to check
- fwd_hit  out  1  combinational: a pending store matches fwd_addr
- fwd_data  out  log_mem_size  combinational: data of the youngest match, 0 when no hit
- count  out  $clog2(depth+1)  occupied entries
- empty  out  1  count == 0 and mem_we == 0

## Operation
- **Push:** at a clk edge with st_valid && st_ready, write {st_addr, st_data} at the write pointer and advance the pointer.
- **Pop:** at a clk edge with count > 0 and !mem_stall, remove the head entry and advance the read pointer. On the same edge, load mem_we=1, mem_waddr and mem_wdata from that entry.
- **No pop:** on any edge without a pop, mem_we goes to 0. mem_waddr and mem_wdata hold their values.
- **Pointers and count:** both pointers wrap modulo depth. count increments on push only, decrements on pop only, and is unchanged when both happen on the same edge.
- **st_ready at full:** st_ready depends only on count, so a pop on the same edge never lets a push into a full buffer.
- **Ordering:** strictly FIFO; stores to the same address are never merged or reordered.
- **Forwarding search:**
  - Candidates are every valid buffer entry plus the in-flight output register. The in-flight register is a candidate when mem_we=1, because memory has not committed that write yet.
  - Age order, oldest first: in-flight register, head entry, …, tail entry.
  - The youngest matching candidate wins.
- **Reset:** rst_n low immediately clears pointers, count, mem_we, mem_waddr and mem_wdata to 0. All entries are discarded, including during an active drain. No partial write is issued. st_ready reads 1 while in reset and after it.

## Timing
- **Store latency on an empty buffer:**
  - Push at edge T.
  - Pop at edge T+1; mem_we is high in the cycle after T+1.
  - Memory commits at edge T+2.
- **Throughput:** one push and one pop per cycle sustained. A full buffer with no stall accepts again in the cycle after the next pop.
- **mem_stall:** sampled at the edge. A stall on the edge after a pop leaves the already-issued mem_we pulse unaffected.
- **Forwarding:** fwd_hit and fwd_data are purely combinational from fwd_addr and current state, with no added cycle. Ties cannot occur because candidates are age-ordered.

## Structure
- **Shared package mem_pkg:** address/data width constants and the store entry struct {addr, data}. The data memory and the pipeline MEM stage use the same package.
- **Sub-module store_buffer_fifo:** storage array, pointers, count, and a per-entry valid vector exported for the forwarding compare.
- **store_write_buffer top:** output register, forwarding priority mux, handshake.

## Test plan
- **Single store:** reset, then push addr 0x06 data 0x42 at edge 0. Required: mem_we=1 with mem_waddr=0x06 and mem_wdata=0x42 in exactly the cycle after edge 1; empty=1 two cycles later.
- **Fill and stall:** hold mem_stall=1 and push 4 stores (0x01..0x04). Required: st_ready=0 after the 4th; a 5th request is held. Release mem_stall. Required: writes 0x01, 0x02, 0x03, 0x04 on consecutive cycles; the 5th store is accepted the cycle after the first pop.
- **Forward priority:** with mem_stall=1, push (0x08, 0x01) then (0x08, 0x09) then (0x01, 0x00). Required: fwd_addr=0x08 gives hit=1, data=0x09; fwd_addr=0x01 gives hit=1, data=0x00; fwd_addr=0x20 gives hit=0, data=0.
- **In-flight forward:** one entry (0x10, 0x77) pops. Required: while mem_we=1, fwd_addr=0x10 gives hit=1, data=0x77; the next cycle gives hit=0.
- **Simultaneous push/pop:** push and pop on the same edge at count 2. Required: count stays 2 and order is preserved. Push attempted when full with a pop on the same edge: required to be refused.
- **Reset mid-drain:** assert rst_n low with 3 entries and mem_we=1. Required: mem_we=0, count=0, st_ready=1 immediately. After release, no write of the old entries ever appears.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared data-memory definitions: word geometry and the store entry layout
// used by the MEM stage, the store write buffer and the data memory.
package mem_pkg;

  localparam int unsigned mem_words = 256;
  localparam int unsigned word_bits = 8;

  typedef logic [word_bits-1:0] word_t;

  typedef struct packed {
    word_t addr;
    word_t data;
  } store_entry_t;

endpackage

// File: rtl/store_buffer_fifo.sv
// In-order storage for pending stores: circular array, pointers, occupancy
// and a per-entry valid vector for the forwarding compare.
module store_buffer_fifo
  import mem_pkg::*;
#(
  parameter int unsigned depth = 4,
  localparam int unsigned ptr_bits = $clog2(depth),
  localparam int unsigned cnt_bits = $clog2(depth + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  store_entry_t             wr_entry,
  output store_entry_t [depth-1:0] entries,
  output logic [depth-1:0]         valid,
  output logic [ptr_bits-1:0]      rd_ptr,
  output logic [cnt_bits-1:0]      count
);

  store_entry_t [depth-1:0] mem_r;
  logic [ptr_bits-1:0]      wr_ptr_r;
  logic [ptr_bits-1:0]      rd_ptr_r;
  logic [cnt_bits-1:0]      count_r;
  logic [ptr_bits-1:0]      offset_s;

  // Storage, pointer and occupancy update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_r    <= '0;
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push) begin
        mem_r[wr_ptr_r] <= wr_entry;
        wr_ptr_r        <= wr_ptr_r + ptr_bits'(1);
      end
      if (pop) begin
        rd_ptr_r <= rd_ptr_r + ptr_bits'(1);
      end
      case ({push, pop})
        2'b10:   count_r <= count_r + cnt_bits'(1);
        2'b01:   count_r <= count_r - cnt_bits'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // An entry is live when its distance from the head is below the occupancy
  always_comb begin
    valid    = '0;
    offset_s = '0;
    for (int i = 0; i < int'(depth); i++) begin
      offset_s = ptr_bits'(i) - rd_ptr_r;
      valid[i] = (cnt_bits'(offset_s) < count_r);
    end
  end

  assign entries = mem_r;
  assign rd_ptr  = rd_ptr_r;
  assign count   = count_r;

endmodule

// File: rtl/store_write_buffer.sv
// Store write buffer: queues MEM-stage stores, drains one per cycle onto the
// registered memory write port, and forwards the youngest pending store data.
module store_write_buffer
  import mem_pkg::*;
#(
  parameter int unsigned mem_size     = mem_words,
  parameter int unsigned log_mem_size = $clog2(mem_size),
  parameter int unsigned depth        = 4,
  localparam int unsigned ptr_bits    = $clog2(depth),
  localparam int unsigned cnt_bits    = $clog2(depth + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    st_valid,
  output logic                    st_ready,
  input  logic [log_mem_size-1:0] st_addr,
  input  logic [log_mem_size-1:0] st_data,
  input  logic                    mem_stall,
  output logic                    mem_we,
  output logic [log_mem_size-1:0] mem_waddr,
  output logic [log_mem_size-1:0] mem_wdata,
  input  logic [log_mem_size-1:0] fwd_addr,
  output logic                    fwd_hit,
  output logic [log_mem_size-1:0] fwd_data,
  output logic [cnt_bits-1:0]     count,
  output logic                    empty
);

  store_entry_t [depth-1:0] entries_s;
  store_entry_t             wr_entry_s;
  store_entry_t             head_s;
  logic [depth-1:0]         valid_s;
  logic [ptr_bits-1:0]      rd_ptr_s;
  logic [cnt_bits-1:0]      count_s;
  logic                     push_s;
  logic                     pop_s;
  logic [ptr_bits-1:0]      idx_s;
  logic                     match_s;

  logic                     mem_we_r;
  logic [log_mem_size-1:0]  mem_waddr_r;
  logic [log_mem_size-1:0]  mem_wdata_r;

  // Ready looks only at occupancy so a same-edge pop never admits a push into a full buffer
  assign st_ready   = (count_s < cnt_bits'(depth));
  assign push_s     = st_valid && st_ready;
  assign pop_s      = (count_s != cnt_bits'(0)) && !mem_stall;
  assign wr_entry_s = '{addr: st_addr, data: st_data};
  assign head_s     = entries_s[rd_ptr_s];

  store_buffer_fifo #(
    .depth(depth)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push_s),
    .pop     (pop_s),
    .wr_entry(wr_entry_s),
    .entries (entries_s),
    .valid   (valid_s),
    .rd_ptr  (rd_ptr_s),
    .count   (count_s)
  );

  // Memory write port register: one strobe per popped entry, address/data hold otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_we_r    <= 1'b0;
      mem_waddr_r <= '0;
      mem_wdata_r <= '0;
    end else if (pop_s) begin
      mem_we_r    <= 1'b1;
      mem_waddr_r <= head_s.addr;
      mem_wdata_r <= head_s.data;
    end else begin
      mem_we_r    <= 1'b0;
    end
  end

  // Forwarding: walk candidates oldest to youngest so the last match wins
  always_comb begin
    fwd_hit  = mem_we_r && (mem_waddr_r == fwd_addr);
    fwd_data = fwd_hit ? mem_wdata_r : '0;
    idx_s    = '0;
    match_s  = 1'b0;
    for (int k = 0; k < int'(depth); k++) begin
      idx_s    = rd_ptr_s + ptr_bits'(k);
      match_s  = valid_s[idx_s] && (entries_s[idx_s].addr == fwd_addr);
      fwd_hit  = fwd_hit | match_s;
      fwd_data = match_s ? entries_s[idx_s].data : fwd_data;
    end
  end

  assign mem_we    = mem_we_r;
  assign mem_waddr = mem_waddr_r;
  assign mem_wdata = mem_wdata_r;
  assign count     = count_s;
  assign empty     = (count_s == cnt_bits'(0)) && !mem_we_r;

endmodule

// File: tb/tb_store_write_buffer.sv
// Scoreboard bench for store_write_buffer: directed stores queue expected
// writes; a monitor compares every memory write strobe against the queue.
module tb_store_write_buffer;

  logic       clk;
  logic       rst_n;
  logic       st_valid;
  logic       st_ready;
  logic [7:0] st_addr;
  logic [7:0] st_data;
  logic       mem_stall;
  logic       mem_we;
  logic [7:0] mem_waddr;
  logic [7:0] mem_wdata;
  logic [7:0] fwd_addr;
  logic       fwd_hit;
  logic [7:0] fwd_data;
  logic [2:0] count;
  logic       empty;

  int checks;
  int failures;
  logic [15:0] exp_q[$];

  store_write_buffer dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .st_valid (st_valid),
    .st_ready (st_ready),
    .st_addr  (st_addr),
    .st_data  (st_data),
    .mem_stall(mem_stall),
    .mem_we   (mem_we),
    .mem_waddr(mem_waddr),
    .mem_wdata(mem_wdata),
    .fwd_addr (fwd_addr),
    .fwd_hit  (fwd_hit),
    .fwd_data (fwd_data),
    .count    (count),
    .empty    (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [7:0] a, input logic [7:0] d, input bit expect_write);
    st_valid = 1'b1;
    st_addr  = a;
    st_data  = d;
    if (expect_write) exp_q.push_back({a, d});
  endtask

  // Monitor: every write strobe must match the oldest expected store
  initial begin
    logic [15:0] e;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && mem_we === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_write actual=0x%0h:0x%0h required=none", mem_waddr, mem_wdata);
        end else begin
          e = exp_q.pop_front();
          check("write_addr", {24'd0, mem_waddr}, {24'd0, e[15:8]});
          check("write_data", {24'd0, mem_wdata}, {24'd0, e[7:0]});
        end
      end
    end
  end

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    st_valid = 1'b0;
    st_addr = 8'h00;
    st_data = 8'h00;
    mem_stall = 1'b0;
    fwd_addr = 8'h00;
    #2;
    check("reset_ready", {31'd0, st_ready}, 32'd1);
    check("reset_count", {29'd0, count}, 32'd0);
    check("reset_we", {31'd0, mem_we}, 32'd0);
    check("reset_empty", {31'd0, empty}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Single store latency
    present(8'h06, 8'h42, 1'b1);
    step();
    st_valid = 1'b0;
    check("single_we_t0", {31'd0, mem_we}, 32'd0);
    check("single_count_t0", {29'd0, count}, 32'd1);
    step();
    check("single_we_t1", {31'd0, mem_we}, 32'd1);
    check("single_waddr_t1", {24'd0, mem_waddr}, 32'h06);
    check("single_wdata_t1", {24'd0, mem_wdata}, 32'h42);
    check("single_empty_t1", {31'd0, empty}, 32'd0);
    step();
    check("single_we_t2", {31'd0, mem_we}, 32'd0);
    step();
    check("single_empty_t3", {31'd0, empty}, 32'd1);

    // Fill under stall, then drain with a held fifth request
    mem_stall = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      present(8'(i), 8'(8'hA0 + i), 1'b1);
      step();
    end
    check("fill_count", {29'd0, count}, 32'd4);
    check("fill_ready", {31'd0, st_ready}, 32'd0);
    present(8'h05, 8'hA5, 1'b1);
    step();
    check("full_held_count", {29'd0, count}, 32'd4);
    mem_stall = 1'b0;
    step();
    check("drain1_count", {29'd0, count}, 32'd3);
    check("drain1_waddr", {24'd0, mem_waddr}, 32'h01);
    check("drain1_ready", {31'd0, st_ready}, 32'd1);
    step();
    st_valid = 1'b0;
    check("drain2_count", {29'd0, count}, 32'd3);
    check("drain2_waddr", {24'd0, mem_waddr}, 32'h02);
    for (int i = 3; i <= 5; i++) begin
      step();
      check("drain_we", {31'd0, mem_we}, 32'd1);
      check("drain_waddr", {24'd0, mem_waddr}, 32'(i));
    end
    step();
    check("drain_done_empty", {31'd0, empty}, 32'd1);

    // Simultaneous push and pop at count 2
    mem_stall = 1'b1;
    present(8'h30, 8'hB0, 1'b1);
    step();
    present(8'h31, 8'hB1, 1'b1);
    step();
    mem_stall = 1'b0;
    present(8'h32, 8'hB2, 1'b1);
    step();
    st_valid = 1'b0;
    check("simul_count", {29'd0, count}, 32'd2);
    check("simul_waddr", {24'd0, mem_waddr}, 32'h30);
    repeat (3) step();
    check("simul_empty", {31'd0, empty}, 32'd1);

    // Forward priority among buffered stores
    mem_stall = 1'b1;
    present(8'h08, 8'h01, 1'b1);
    step();
    present(8'h08, 8'h09, 1'b1);
    step();
    present(8'h01, 8'h00, 1'b1);
    step();
    st_valid = 1'b0;
    fwd_addr = 8'h08;
    #1;
    check("fwd08_hit", {31'd0, fwd_hit}, 32'd1);
    check("fwd08_data", {24'd0, fwd_data}, 32'h09);
    fwd_addr = 8'h01;
    #1;
    check("fwd01_hit", {31'd0, fwd_hit}, 32'd1);
    check("fwd01_data", {24'd0, fwd_data}, 32'h00);
    fwd_addr = 8'h20;
    #1;
    check("fwd20_hit", {31'd0, fwd_hit}, 32'd0);
    check("fwd20_data", {24'd0, fwd_data}, 32'h00);
    mem_stall = 1'b0;
    step();
    fwd_addr = 8'h08;
    #1;
    check("fwd_young_over_inflight", {24'd0, fwd_data}, 32'h09);
    repeat (3) step();

    // In-flight register forwarding
    present(8'h10, 8'h77, 1'b1);
    fwd_addr = 8'h10;
    step();
    st_valid = 1'b0;
    step();
    check("inflight_we", {31'd0, mem_we}, 32'd1);
    check("inflight_hit", {31'd0, fwd_hit}, 32'd1);
    check("inflight_data", {24'd0, fwd_data}, 32'h77);
    step();
    check("inflight_after_hit", {31'd0, fwd_hit}, 32'd0);
    check("inflight_after_data", {24'd0, fwd_data}, 32'h00);

    // Reset mid-drain: none of these stores may ever reach memory
    mem_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      present(8'(8'h40 + i), 8'(8'hC0 + i), 1'b0);
      step();
    end
    st_valid = 1'b0;
    mem_stall = 1'b0;
    step();
    check("predrain_we", {31'd0, mem_we}, 32'd1);
    check("predrain_count", {29'd0, count}, 32'd3);
    rst_n = 1'b0;
    #1;
    check("rst_we", {31'd0, mem_we}, 32'd0);
    check("rst_count", {29'd0, count}, 32'd0);
    check("rst_ready", {31'd0, st_ready}, 32'd1);
    step();
    step();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) step();
    check("post_rst_count", {29'd0, count}, 32'd0);
    check("post_rst_ready", {31'd0, st_ready}, 32'd1);
    check("exp_queue_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
